// File: rtl/lsu_seq_pkg.sv
// Shared types and decode helpers for the multi-cycle load-store unit.
package lsu_seq_pkg;

    typedef enum logic [3:0] {
        LS_NONE,
        LS_LB,
        LS_LH,
        LS_LW,
        LS_LBU,
        LS_LHU,
        LS_SB,
        LS_SH,
        LS_SW
    } lsu_ls_t;

    typedef enum logic {
        MEM_ROM,
        MEM_DMEM
    } lsu_mem_src_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } lsu_size_t;

    function automatic lsu_size_t ls_size(input lsu_ls_t op);
        case (op)
            LS_LB, LS_LBU, LS_SB: return SZ_B;
            LS_LH, LS_LHU, LS_SH: return SZ_H;
            default:              return SZ_W;
        endcase
    endfunction

    function automatic logic ls_is_store(input lsu_ls_t op);
        return (op == LS_SB) || (op == LS_SH) || (op == LS_SW);
    endfunction

    function automatic logic ls_is_unsigned(input lsu_ls_t op);
        return (op == LS_LBU) || (op == LS_LHU);
    endfunction

endpackage

// File: rtl/lsu_seq_if.sv
// Core-side handshake and memory-bus signals of the load-store unit.
interface lsu_seq_if
    import lsu_seq_pkg::*;
#(
    parameter int unsigned XLEN = 32
);
    logic              i_req_valid;
    logic              o_req_ready;
    lsu_ls_t           i_op;
    logic [XLEN-1:0]   i_addr;
    logic [XLEN-1:0]   i_wdata;
    logic              i_flush;
    logic              o_rsp_valid;
    logic [XLEN-1:0]   o_rdata;
    logic              o_t_load_addr_misaligned;
    logic              o_t_load_access_fault;
    logic              o_t_store_addr_misaligned;
    logic              o_t_store_access_fault;
    logic              o_mem_req;
    lsu_mem_src_t      o_mem_sel;
    logic              o_mem_we;
    logic [XLEN-1:0]   o_mem_addr;
    logic [XLEN-1:0]   o_mem_wdata;
    logic [XLEN/8-1:0] o_mem_wstrb;
    logic              i_mem_gnt;
    logic              i_mem_rvalid;
    logic [XLEN-1:0]   i_mem_rdata;
    logic              i_mem_err;

    modport slave (
        input  i_req_valid, i_op, i_addr, i_wdata, i_flush,
               i_mem_gnt, i_mem_rvalid, i_mem_rdata, i_mem_err,
        output o_req_ready, o_rsp_valid, o_rdata,
               o_t_load_addr_misaligned, o_t_load_access_fault,
               o_t_store_addr_misaligned, o_t_store_access_fault,
               o_mem_req, o_mem_sel, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb
    );

    modport master (
        output i_req_valid, i_op, i_addr, i_wdata, i_flush,
               i_mem_gnt, i_mem_rvalid, i_mem_rdata, i_mem_err,
        input  o_req_ready, o_rsp_valid, o_rdata,
               o_t_load_addr_misaligned, o_t_load_access_fault,
               o_t_store_addr_misaligned, o_t_store_access_fault,
               o_mem_req, o_mem_sel, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store data/strobe shifted into place, load data
// shifted down to bit 0 and sign/zero-extended by operation size.
module lsu_lane_align
    import lsu_seq_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  lsu_ls_t                    op,
    input  logic [$clog2(XLEN/8)-1:0]  offset,
    input  logic [XLEN-1:0]            wdata,
    input  logic [XLEN-1:0]            mem_rdata,
    output logic [XLEN-1:0]            mem_wdata,
    output logic [XLEN/8-1:0]          mem_wstrb,
    output logic [XLEN-1:0]            rdata
);
    localparam int unsigned SW = XLEN / 8;

    logic [$clog2(XLEN/8)+2:0] bit_shift;
    logic [XLEN-1:0]           shifted;
    logic [SW-1:0]             strb_base;

    assign bit_shift = {offset, 3'b000};
    assign mem_wdata = wdata << bit_shift;
    assign mem_wstrb = strb_base << offset;
    assign shifted   = mem_rdata >> bit_shift;

    always_comb begin
        strb_base = '0;
        rdata     = '0;
        case (ls_size(op))
            SZ_B: begin
                strb_base = SW'(4'h1);
                rdata = ls_is_unsigned(op) ? XLEN'(shifted[7:0])
                                           : XLEN'($signed(shifted[7:0]));
            end
            SZ_H: begin
                strb_base = SW'(4'h3);
                rdata = ls_is_unsigned(op) ? XLEN'(shifted[15:0])
                                           : XLEN'($signed(shifted[15:0]));
            end
            default: begin
                strb_base = SW'(4'hF);
                rdata = XLEN'($signed(shifted[31:0]));
            end
        endcase
    end

endmodule

// File: rtl/lsu_seq.sv
// Multi-cycle load-store unit: region decode, alignment checks and a
// request/grant/response bus transaction with timeout and flush handling.
module lsu_seq
    import lsu_seq_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter logic [31:0] ROM_BASE  = 32'h0000_0000,
    parameter logic [31:0] ROM_SIZE  = 32'h0000_4000,
    parameter logic [31:0] DMEM_BASE = 32'h1000_0000,
    parameter logic [31:0] DMEM_SIZE = 32'h0000_4000,
    parameter int unsigned TIMEOUT   = 16
) (
    input logic     i_clk,
    input logic     i_rst,
    lsu_seq_if.slave bus
);
    localparam int unsigned     SW        = XLEN / 8;
    localparam int unsigned     OFFW      = $clog2(SW);
    localparam int unsigned     CW        = $clog2(TIMEOUT + 1);
    localparam logic [XLEN-1:0] ROM_B     = XLEN'(ROM_BASE);
    localparam logic [XLEN-1:0] ROM_S     = XLEN'(ROM_SIZE);
    localparam logic [XLEN-1:0] DMEM_B    = XLEN'(DMEM_BASE);
    localparam logic [XLEN-1:0] DMEM_S    = XLEN'(DMEM_SIZE);
    localparam logic [XLEN-1:0] WORD_MASK = ~(XLEN'(SW - 1));

    lsu_state_t      state;
    lsu_ls_t         op_q;
    logic [OFFW-1:0] off_q;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_inc;
    logic            req_ready, rsp_q, mem_req, mem_we;
    lsu_mem_src_t    mem_sel;
    logic [XLEN-1:0] rdata, mem_addr, mem_wdata;
    logic [SW-1:0]   mem_wstrb;
    logic            t_lmis, t_lacc, t_smis, t_sacc;

    logic [XLEN-1:0] rom_rel, dmem_rel;
    logic            in_rom, in_dmem, st, st_q, misaligned, fault, accept;
    lsu_size_t       size;
    lsu_ls_t         al_op;
    logic [OFFW-1:0] al_off;
    logic [XLEN-1:0] al_wdata, al_rdata, fin_rdata;
    logic [SW-1:0]   al_wstrb;

    // Region hit uses wrap-safe relative offsets, so no upper-bound overflow.
    assign rom_rel    = bus.i_addr - ROM_B;
    assign dmem_rel   = bus.i_addr - DMEM_B;
    assign in_rom     = rom_rel < ROM_S;
    assign in_dmem    = dmem_rel < DMEM_S;
    assign st         = ls_is_store(bus.i_op);
    assign st_q       = ls_is_store(op_q);
    assign size       = ls_size(bus.i_op);
    assign misaligned = ((size == SZ_H) && bus.i_addr[0]) ||
                        ((size == SZ_W) && (bus.i_addr[1:0] != 2'b00));
    assign fault      = !(in_rom || in_dmem) || (st && in_rom);
    assign accept     = bus.i_req_valid && req_ready && (bus.i_op != LS_NONE) && !bus.i_flush;
    assign cnt_inc    = cnt + 1'b1;
    assign fin_rdata  = (bus.i_mem_err || st_q) ? '0 : al_rdata;

    // The aligner sees the incoming op while idle and the held op afterwards.
    assign al_op  = (state == S_IDLE) ? bus.i_op : op_q;
    assign al_off = (state == S_IDLE) ? bus.i_addr[OFFW-1:0] : off_q;

    lsu_lane_align #(.XLEN(XLEN)) u_align (
        .op        (al_op),
        .offset    (al_off),
        .wdata     (bus.i_wdata),
        .mem_rdata (bus.i_mem_rdata),
        .mem_wdata (al_wdata),
        .mem_wstrb (al_wstrb),
        .rdata     (al_rdata)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= S_IDLE;
            op_q      <= LS_NONE;
            off_q     <= '0;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_q     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_sel   <= MEM_ROM;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            rdata     <= '0;
            t_lmis    <= 1'b0;
            t_lacc    <= 1'b0;
            t_smis    <= 1'b0;
            t_sacc    <= 1'b0;
        end else begin
            rsp_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q      <= bus.i_op;
                        off_q     <= bus.i_addr[OFFW-1:0];
                        req_ready <= 1'b0;
                        rdata     <= '0;
                        t_lmis    <= 1'b0;
                        t_lacc    <= 1'b0;
                        t_smis    <= 1'b0;
                        t_sacc    <= 1'b0;
                        if (misaligned) begin
                            t_lmis <= !st;
                            t_smis <= st;
                            rsp_q  <= 1'b1;
                            state  <= S_RESP;
                        end else if (fault) begin
                            t_lacc <= !st;
                            t_sacc <= st;
                            rsp_q  <= 1'b1;
                            state  <= S_RESP;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= st;
                            mem_sel   <= in_rom ? MEM_ROM : MEM_DMEM;
                            mem_addr  <= (in_rom ? rom_rel : dmem_rel) & WORD_MASK;
                            mem_wdata <= st ? al_wdata : '0;
                            mem_wstrb <= st ? al_wstrb : '0;
                            state     <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    cnt <= '0;
                    if (bus.i_mem_gnt || bus.i_flush) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                    // A request granted in the flush cycle still owes a response beat.
                    if (bus.i_flush) begin
                        if (bus.i_mem_gnt && !bus.i_mem_rvalid) begin
                            state <= S_DRAIN;
                        end else begin
                            state     <= S_IDLE;
                            req_ready <= 1'b1;
                        end
                    end else if (bus.i_mem_gnt) begin
                        if (bus.i_mem_rvalid) begin
                            rdata  <= fin_rdata;
                            t_lacc <= bus.i_mem_err && !st_q;
                            t_sacc <= bus.i_mem_err && st_q;
                            rsp_q  <= 1'b1;
                            state  <= S_RESP;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    cnt <= cnt_inc;
                    if (bus.i_flush) begin
                        if (bus.i_mem_rvalid) begin
                            state     <= S_IDLE;
                            req_ready <= 1'b1;
                        end else begin
                            cnt   <= '0;
                            state <= S_DRAIN;
                        end
                    end else if (bus.i_mem_rvalid) begin
                        rdata  <= fin_rdata;
                        t_lacc <= bus.i_mem_err && !st_q;
                        t_sacc <= bus.i_mem_err && st_q;
                        rsp_q  <= 1'b1;
                        state  <= S_RESP;
                    end else if (cnt_inc == CW'(TIMEOUT)) begin
                        rdata  <= '0;
                        t_lacc <= !st_q;
                        t_sacc <= st_q;
                        rsp_q  <= 1'b1;
                        state  <= S_RESP;
                    end
                end
                S_RESP: begin
                    rdata     <= '0;
                    t_lmis    <= 1'b0;
                    t_lacc    <= 1'b0;
                    t_smis    <= 1'b0;
                    t_sacc    <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                S_DRAIN: begin
                    cnt <= cnt_inc;
                    if (bus.i_mem_rvalid || (cnt_inc == CW'(TIMEOUT))) begin
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    // A flush arriving during the response cycle cancels the pulse.
    assign bus.o_rsp_valid               = rsp_q && !bus.i_flush;
    assign bus.o_req_ready               = req_ready;
    assign bus.o_rdata                   = rdata;
    assign bus.o_t_load_addr_misaligned  = t_lmis;
    assign bus.o_t_load_access_fault     = t_lacc;
    assign bus.o_t_store_addr_misaligned = t_smis;
    assign bus.o_t_store_access_fault    = t_sacc;
    assign bus.o_mem_req                 = mem_req;
    assign bus.o_mem_sel                 = mem_sel;
    assign bus.o_mem_we                  = mem_we;
    assign bus.o_mem_addr                = mem_addr;
    assign bus.o_mem_wdata               = mem_wdata;
    assign bus.o_mem_wstrb               = mem_wstrb;

endmodule

// File: tb/tb_lsu_seq.sv
// Directed scoreboard bench for lsu_seq: expected responses are queued at issue
// and compared when the response pulse appears.
module tb_lsu_seq;
    import lsu_seq_pkg::*;

    typedef struct packed {
        logic [31:0] rdata;
        logic [3:0]  traps;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    tests = 0;
    int    fails = 0;
    int    pushed = 0;
    int    rsp_seen = 0;
    int    waited;
    int    snap;
    exp_t  sb[$];
    string tagq[$];

    lsu_seq_if #(.XLEN(32)) bus ();

    lsu_seq #(.XLEN(32)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.o_rsp_valid === 1'b1) rsp_seen++;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input lsu_ls_t op, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit want, input logic [31:0] rd, input logic [3:0] tr,
                         input string tag);
        check({tag, "_ready"}, 32'(bus.o_req_ready), 32'd1);
        bus.i_req_valid = 1'b1;
        bus.i_op        = op;
        bus.i_addr      = addr;
        bus.i_wdata     = wdata;
        if (want) begin
            sb.push_back('{rdata: rd, traps: tr});
            tagq.push_back(tag);
            pushed++;
        end
        @(posedge clk); #1;
        bus.i_req_valid = 1'b0;
        bus.i_op        = LS_NONE;
    endtask

    task automatic bus_cycle(input bit gnt, input bit rv, input logic [31:0] rd,
                             input bit err, input bit fl);
        bus.i_mem_gnt    = gnt;
        bus.i_mem_rvalid = rv;
        bus.i_mem_rdata  = rd;
        bus.i_mem_err    = err;
        bus.i_flush      = fl;
        @(posedge clk); #1;
        bus.i_mem_gnt    = 1'b0;
        bus.i_mem_rvalid = 1'b0;
        bus.i_mem_rdata  = '0;
        bus.i_mem_err    = 1'b0;
        bus.i_flush      = 1'b0;
    endtask

    task automatic expect_rsp(input int max_cycles, output int n);
        exp_t  e;
        string tag;
        n = 0;
        while (bus.o_rsp_valid !== 1'b1 && n < max_cycles) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            tag = tagq.pop_front();
        end else begin
            e   = '0;
            tag = "unexpected";
        end
        check({tag, "_rsp_valid"}, 32'(bus.o_rsp_valid), 32'd1);
        check({tag, "_rdata"}, bus.o_rdata, e.rdata);
        check({tag, "_traps"}, 32'({bus.o_t_load_addr_misaligned, bus.o_t_load_access_fault,
                                    bus.o_t_store_addr_misaligned, bus.o_t_store_access_fault}),
              32'(e.traps));
        @(posedge clk); #1;
        check({tag, "_pulse_end"}, 32'(bus.o_rsp_valid), 32'd0);
    endtask

    initial begin
        bus.i_req_valid  = 1'b0;
        bus.i_op         = LS_NONE;
        bus.i_addr       = '0;
        bus.i_wdata      = '0;
        bus.i_flush      = 1'b0;
        bus.i_mem_gnt    = 1'b0;
        bus.i_mem_rvalid = 1'b0;
        bus.i_mem_rdata  = '0;
        bus.i_mem_err    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.o_req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
        check("rst_mem_req", 32'(bus.o_mem_req), 32'd0);
        check("rst_mem_addr", bus.o_mem_addr, 32'd0);
        check("rst_mem_wstrb", 32'(bus.o_mem_wstrb), 32'd0);
        check("rst_rdata", bus.o_rdata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // NONE op is ignored
        issue(LS_NONE, 32'h1000_0000, 32'h0, 1'b0, 32'h0, 4'h0, "none");
        check("none_ready", 32'(bus.o_req_ready), 32'd1);
        check("none_mem_req", 32'(bus.o_mem_req), 32'd0);

        // LB sign-extended from byte lane 3
        issue(LS_LB, 32'h1000_0003, 32'h0, 1'b1, 32'hFFFF_FF80, 4'h0, "lb");
        check("lb_mem_req", 32'(bus.o_mem_req), 32'd1);
        check("lb_mem_addr", bus.o_mem_addr, 32'd0);
        check("lb_mem_we", 32'(bus.o_mem_we), 32'd0);
        check("lb_mem_sel", 32'(bus.o_mem_sel), 32'(MEM_DMEM));
        bus_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        bus_cycle(1'b0, 1'b1, 32'h80FF_1234, 1'b0, 1'b0);
        expect_rsp(2, waited);

        // SH into upper half, held without grant, then grant+rvalid together
        issue(LS_SH, 32'h1000_0002, 32'h0000_BEEF, 1'b1, 32'h0, 4'h0, "sh");
        check("sh_wstrb", 32'(bus.o_mem_wstrb), 32'h0000_000C);
        check("sh_wdata", bus.o_mem_wdata, 32'hBEEF_0000);
        check("sh_addr", bus.o_mem_addr, 32'd0);
        check("sh_we", 32'(bus.o_mem_we), 32'd1);
        bus_cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("sh_hold_req", 32'(bus.o_mem_req), 32'd1);
        check("sh_hold_wdata", bus.o_mem_wdata, 32'hBEEF_0000);
        bus_cycle(1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
        expect_rsp(2, waited);

        // Misaligned and access-fault cases respond without a bus request
        issue(LS_LW, 32'h1000_0001, 32'h0, 1'b1, 32'h0, 4'b1000, "lw_mis");
        check("lw_mis_no_req", 32'(bus.o_mem_req), 32'd0);
        expect_rsp(0, waited);
        issue(LS_SW, 32'h0000_0004, 32'h1234_5678, 1'b1, 32'h0, 4'b0001, "sw_rom");
        check("sw_rom_no_req", 32'(bus.o_mem_req), 32'd0);
        expect_rsp(0, waited);
        issue(LS_LW, 32'hF000_0000, 32'h0, 1'b1, 32'h0, 4'b0100, "lw_far");
        expect_rsp(0, waited);
        issue(LS_SH, 32'h0000_0001, 32'h0, 1'b1, 32'h0, 4'b0010, "sh_rom_mis");
        expect_rsp(0, waited);
        issue(LS_LH, 32'h1000_4000, 32'h0, 1'b1, 32'h0, 4'b0100, "lh_dmem_end");
        expect_rsp(0, waited);

        // Timeout: grant, then no rvalid
        issue(LS_LW, 32'h1000_0004, 32'h0, 1'b1, 32'h0, 4'b0100, "lw_tmo");
        check("lw_tmo_addr", bus.o_mem_addr, 32'd4);
        bus_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        expect_rsp(40, waited);
        check("lw_tmo_latency", 32'(waited), 32'd16);

        // LH after a delayed grant, LHU with bus error, LBU with same-cycle grant
        issue(LS_LH, 32'h1000_0002, 32'h0, 1'b1, 32'hFFFF_BEEF, 4'h0, "lh");
        bus_cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        bus_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        bus_cycle(1'b0, 1'b1, 32'hBEEF_1234, 1'b0, 1'b0);
        expect_rsp(2, waited);
        issue(LS_LHU, 32'h1000_0002, 32'h0, 1'b1, 32'h0, 4'b0100, "lhu_err");
        bus_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        bus_cycle(1'b0, 1'b1, 32'hBEEF_1234, 1'b1, 1'b0);
        expect_rsp(2, waited);
        issue(LS_LBU, 32'h1000_0001, 32'h0, 1'b1, 32'h0000_00F5, 4'h0, "lbu");
        bus_cycle(1'b1, 1'b1, 32'h0000_F500, 1'b0, 1'b0);
        expect_rsp(2, waited);

        // Flush in WAIT: drain the late rvalid, no response
        snap = rsp_seen;
        issue(LS_LW, 32'h1000_0008, 32'h0, 1'b0, 32'h0, 4'h0, "flush_wait");
        bus_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        bus_cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("flush_wait_busy", 32'(bus.o_req_ready), 32'd0);
        bus_cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        bus_cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        bus_cycle(1'b0, 1'b1, 32'h1111_2222, 1'b0, 1'b0);
        check("flush_wait_ready", 32'(bus.o_req_ready), 32'd1);
        check("flush_wait_no_rsp", 32'(rsp_seen), 32'(snap));

        // Flush in REQ and flush during RESP
        issue(LS_LW, 32'h1000_0008, 32'h0, 1'b0, 32'h0, 4'h0, "flush_req");
        bus_cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("flush_req_ready", 32'(bus.o_req_ready), 32'd1);
        check("flush_req_mem_req", 32'(bus.o_mem_req), 32'd0);
        issue(LS_LW, 32'h1000_0001, 32'h0, 1'b0, 32'h0, 4'h0, "flush_rsp");
        bus.i_flush = 1'b1;
        #1;
        check("flush_rsp_suppressed", 32'(bus.o_rsp_valid), 32'd0);
        @(posedge clk); #1;
        bus.i_flush = 1'b0;
        check("flush_rsp_no_rsp", 32'(rsp_seen), 32'(snap));

        // Reset asserted mid-REQ drops the request immediately
        issue(LS_LW, 32'h1000_000C, 32'h0, 1'b0, 32'h0, 4'h0, "rst_mid");
        check("rst_mid_req_before", 32'(bus.o_mem_req), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_req_after", 32'(bus.o_mem_req), 32'd0);
        check("rst_mid_addr", bus.o_mem_addr, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_ready", 32'(bus.o_req_ready), 32'd1);

        check("sb_empty", 32'(sb.size()), 32'd0);
        check("rsp_count", 32'(rsp_seen), 32'(pushed));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
